shift_issue_stage: RTL
======================

// Module: shift_issue_stage
// PURPOSE
//  Registered issue stage directly upstream of the 32-bit shifter. Takes a decoded
//  R-type word plus rs/rt values over a valid/ready handshake and decodes the six
//  MIPS shift functs. Selects the shift amount and presents the operand pair in
//  shifter format: amount in A[10:6], data in B.
//  A 2-entry skid buffer fully registers in_ready against downstream stalls.
// PARAMETERS
//  CNT_W   16   width of the stall counter (optional feature only)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   reset, asynchronous assert, active-low
//  flush      in   1   synchronous squash of all buffered ops
//  in_valid   in   1   upstream op valid
//  in_ready   out  1   stage can accept an op this cycle
//  in_instr   in   32  instruction word
//  in_rs      in   32  rs register value (variable-shift amount source)
//  in_rt      in   32  rt register value (data to shift)
//  out_valid  out  1   op presented to shifter
//  out_ready  in   1   shifter/EX consumes op this cycle
//  out_a      out  32  {21'b0, amt[4:0], 6'b0}
//  out_b      out  32  rt value
//  out_op     out  2   00 SLL, 01 SRL, 10 SRA (11 never driven)
//  err        out  1   1-cycle pulse: accepted op was not a shift
//  stall_cnt  out  CNT_W  cycles with out_valid & !out_ready (SHIFT_STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, out_a/out_b=0, out_op=00, err=0, stall_cnt=0, both entries empty.
//  - Transfer on valid&ready at either side. Latency: accept in cycle N -> out_valid in N+1.
//    Throughput: 1 op/cycle when out_ready=1.
//  - Decode: legal only if instr[31:26]==0 and funct instr[5:0] is in
//    {00 sll, 02 srl, 03 sra, 04 sllv, 06 srlv, 07 srav}.
//    amt = instr[10:6] for 00/02/03; amt = rs[4:0] for 04/06/07 (upper rs bits ignored).
//    op = 00 for funct 00/04; 01 for funct 02/06; 10 for funct 03/07.
//  - Illegal op accepted: consumed, never enqueued, err=1 in the next cycle.
//  - Buffer: entries MAIN (drives out_*) and SKID.
//    in_ready = !SKID.full, registered.
//    Accept while MAIN full and not draining -> write SKID.
//    MAIN drains -> SKID moves to MAIN in the same edge.
//    Order is strictly FIFO.
//  - Simultaneous accept + drain with MAIN full and SKID empty: new op goes to MAIN.
//    Occupancy is unchanged.
//  - Both entries full: in_ready=0; any in_valid is ignored with no side effects.
//  - out_* are stable while out_valid & !out_ready (no change until consumed).
//  - flush: next edge empties both entries and sets out_valid=0, in_ready=1.
//    A same-cycle in_valid is dropped; err is suppressed. stall_cnt is not cleared.
//  - Async reset mid-operation discards all ops immediately.
// CONFIGURATION
//  SHIFT_STALL_CNT_EN defined:
//    stall_cnt increments each cycle out_valid & !out_ready; saturates at all-ones.
//  Not defined: stall_cnt is tied to 0 and has no register.
// STRUCTURE
//  Shared package (shift_pkg):
//    funct constants F_SLL..F_SRAV, op encodings OP_SLL/OP_SRL/OP_SRA,
//    and the entry struct {a,b,op}.
//  One natural sub-module: shift_decode (combinational instr/rs -> amt, op, legal).
//  Skid/handshake logic stays in this module.
// TESTING
//  1 sll $t0,$t1,3 (instr 0x000940C0), rt=0x00000001, out_ready=1
//    -> next cycle out_valid=1, out_a=0x000000C0, out_b=1, out_op=00.
//  2 srav, rs=0xFFFFFFE4, rt=0x80000000
//    -> out_a=0x00000100 (amt 4), out_op=10; upper rs bits ignored.
//  3 out_ready=0, 3 back-to-back valid ops -> 2 stored, in_ready=0 after 2nd, 3rd held off.
//    Then out_ready=1 -> ops emerge in order, 1/cycle.
//  4 instr 0x00000020 (add)
//    -> accepted, err pulses 1 cycle, out_valid stays 0; also opcode 0x08 -> err.
//  5 Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no err.
//    Assert rst_n=0 mid-stream -> outputs reset immediately.
//  6 SHIFT_STALL_CNT_EN, CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated).
//    Without macro -> stall_cnt=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift issue stage: MIPS shift funct codes,
// shifter op encodings and the buffered entry format.
package shift_pkg;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One buffered op in shifter format.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an R-type word into shift amount, shifter op and
// a legality flag. Variable shifts take the amount from the low five rs bits.
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [4:0]  rs_lo,
  output logic [4:0]  amt,
  output logic [1:0]  op,
  output logic        legal
);

  // Fields outside opcode, shamt and funct do not affect the decode.
  logic unused_fields;
  assign unused_fields = &{1'b0, instr[25:11]};

  // Map opcode/funct to amount source, op encoding and legality.
  always_comb begin
    amt   = 5'd0;
    op    = OP_SLL;
    legal = 1'b0;
    if (instr[31:26] == 6'd0) begin
      case (instr[5:0])
        F_SLL:   begin amt = instr[10:6]; op = OP_SLL; legal = 1'b1; end
        F_SRL:   begin amt = instr[10:6]; op = OP_SRL; legal = 1'b1; end
        F_SRA:   begin amt = instr[10:6]; op = OP_SRA; legal = 1'b1; end
        F_SLLV:  begin amt = rs_lo;       op = OP_SLL; legal = 1'b1; end
        F_SRLV:  begin amt = rs_lo;       op = OP_SRL; legal = 1'b1; end
        F_SRAV:  begin amt = rs_lo;       op = OP_SRA; legal = 1'b1; end
        default: begin amt = 5'd0;        op = OP_SLL; legal = 1'b0; end
      endcase
    end else begin
      amt   = 5'd0;
      op    = OP_SLL;
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue stage in front of the 32-bit shifter. Decodes MIPS shift
// functs and buffers ops in a two-entry (MAIN + SKID) skid buffer so that
// in_ready comes straight from a flop. Optional stall counter is enabled by
// defining SHIFT_STALL_CNT_EN.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [1:0]       out_op,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0] dec_amt;
  logic [1:0] dec_op;
  logic       dec_legal;

  // Only the low five rs bits ever form a shift amount.
  logic unused_rs;
  assign unused_rs = &{1'b0, in_rs[31:5]};

  shift_decode u_decode (
    .instr (in_instr),
    .rs_lo (in_rs[4:0]),
    .amt   (dec_amt),
    .op    (dec_op),
    .legal (dec_legal)
  );

  entry_t main_q, skid_q, main_d, skid_d, new_entry;
  logic   main_valid, skid_valid, main_valid_d, skid_valid_d;
  logic   err_d;
  logic   accept, drain, enq;

  assign new_entry = '{a: {21'd0, dec_amt, 6'd0}, b: in_rt, op: dec_op};

  // SKID occupancy is itself a flop, so in_ready is registered.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign enq       = accept & dec_legal & ~flush;

  // Next-state for both entries: FIFO order, SKID refills MAIN on drain.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    err_d        = accept & ~dec_legal & ~flush;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (enq) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (enq) begin
      if (main_valid) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end
    end else begin
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
    end
  end

  // Entry storage, valid flags and the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      err        <= err_d;
    end
  end

  assign out_valid = main_valid;
  assign out_a     = main_q.a;
  assign out_b     = main_q.b;
  assign out_op    = main_q.op;

`ifdef SHIFT_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Count cycles the shifter holds off a valid op; saturate, survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
